ram_arbiter: RTL and testbench

- Shares one 64x64 single-port synchronous RAM (`w`, `r`, `addr`, `data_in`, `data_out`) among NREQ requesters.
- Round-robin arbitration grants at most one operation per cycle and drives the RAM control pins; `w` and `r` are never asserted together.
- Tracks the single in-flight read and routes the RAM's registered `data_out` back to the requester that owns it.
- Sits between client engines and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/ram_arbiter.sv | 154 +++++++++++++++
 tb/tb_ram_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: RAM geometry constants, word types and the clear-sweep
// state enum shared by the RAM arbiter. The sweep states are only used
// when RAM_ARB_CLEAR_EN is defined.
package ram_arb_pkg;
    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << AW;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } sweep_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker. The search starts
// one above i_last and wraps modulo NREQ; the first requester found wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int LW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [LW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant
);

    // Distance of each requester from the slot after i_last; smallest wins.
    always_comb begin
        int best_off;
        int best_idx;
        int off;
        best_off = NREQ;
        best_idx = 0;
        off      = 0;
        o_grant  = '0;
        for (int i = 0; i < NREQ; i++) begin
            off = (i + 2 * NREQ - int'(i_last) - 1) % NREQ;
            if (i_req[i] && (off < best_off)) begin
                best_off = off;
                best_idx = i;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            o_grant[i] = (best_off < NREQ) && (best_idx == i);
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM among NREQ clients.
// One operation is granted per cycle; the single in-flight read is tracked
// and its registered RAM data is returned to its owner one cycle later.
// Optional macro RAM_ARB_CLEAR_EN: after reset, zero the whole RAM with one
// write per cycle before arbitration is enabled.
module ram_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = ram_arb_pkg::AW,
    parameter int DW   = ram_arb_pkg::DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               ram_w,
    output logic               ram_r,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_data_in,
    input  logic [DW-1:0]      ram_data_out,
    output logic               init_busy
);
    import ram_arb_pkg::*;

    localparam int LW = $clog2(NREQ);

    logic [NREQ-1:0] w_grant_raw;
    logic [NREQ-1:0] w_grant;
    logic            w_any_grant;
    logic            w_gnt_we;
    logic [LW-1:0]   w_gnt_idx;
    logic [AW-1:0]   w_gnt_addr;
    logic [DW-1:0]   w_gnt_wdata;
    logic            w_sweep;
    logic [AW-1:0]   w_sweep_addr;

    logic [LW-1:0]   r_rr_last;
    logic            r_rd_pend;
    logic [LW-1:0]   r_rd_owner;

    rr_arbiter #(
        .NREQ (NREQ),
        .LW   (LW)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_last  (r_rr_last),
        .o_grant (w_grant_raw)
    );

`ifdef RAM_ARB_CLEAR_EN
    sweep_state_t  r_state;
    logic [AW-1:0] r_sweep_addr;
    logic          r_init_busy;

    // Clear sweep: one zero write per cycle, RUN once the address wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SWEEP;
            r_sweep_addr <= '0;
            r_init_busy  <= 1'b1;
        end else begin
            case (r_state)
                SWEEP: begin
                    r_sweep_addr <= r_sweep_addr + 1'b1;
                    if (&r_sweep_addr) begin
                        r_state     <= RUN;
                        r_init_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= RUN;
                    r_init_busy <= 1'b0;
                end
            endcase
        end
    end

    assign w_sweep      = r_init_busy;
    assign w_sweep_addr = r_sweep_addr;
`else
    assign w_sweep      = 1'b0;
    assign w_sweep_addr = '0;
`endif

    assign init_busy = w_sweep;

    // No client may transfer while in reset or while the RAM is being cleared.
    assign w_grant   = (rst || w_sweep) ? '0 : w_grant_raw;
    assign req_ready = w_grant;

    // Select the granted client's operation; all zero when nobody is granted.
    always_comb begin
        w_gnt_idx   = '0;
        w_gnt_we    = 1'b0;
        w_gnt_addr  = '0;
        w_gnt_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx   = LW'(i);
                w_gnt_we    = req_we[i];
                w_gnt_addr  = req_addr[i*AW +: AW];
                w_gnt_wdata = req_wdata[i*DW +: DW];
            end
        end
        w_any_grant = |w_grant;
    end

    // RAM pins: sweep writes take over the port, otherwise the granted op.
    always_comb begin
        if (w_sweep && !rst) begin
            ram_w       = 1'b1;
            ram_r       = 1'b0;
            ram_addr    = w_sweep_addr;
            ram_data_in = '0;
        end else begin
            ram_w       = w_any_grant & w_gnt_we;
            ram_r       = w_any_grant & ~w_gnt_we;
            ram_addr    = w_gnt_addr;
            ram_data_in = w_gnt_wdata;
        end
    end

    // Round-robin pointer and in-flight read tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last  <= LW'(NREQ - 1);
            r_rd_pend  <= 1'b0;
            r_rd_owner <= '0;
        end else begin
            if (w_any_grant) begin
                r_rr_last <= w_gnt_idx;
            end
            r_rd_pend <= w_any_grant & ~w_gnt_we;
            if (w_any_grant && !w_gnt_we) begin
                r_rd_owner <= w_gnt_idx;
            end
        end
    end

    // Read response goes to the owner of the read issued last cycle.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = r_rd_pend && (r_rd_owner == LW'(i));
        end
    end

    assign rsp_rdata = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a
// behavioural model (round-robin scan, reference memory, pending read).
module tb_ram_arbiter;
    localparam int NREQ  = 2;
    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int DEPTH = 64;
`ifdef RAM_ARB_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               ram_w;
    logic               ram_r;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_data_in;
    logic [DW-1:0]      ram_data_out;
    logic               init_busy;

    always #5 clk = ~clk;

    ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .ram_w        (ram_w),
        .ram_r        (ram_r),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .init_busy    (init_busy)
    );

    // Single-port RAM: registered read, zero output on non-read cycles.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_data_out <= '0;
        end else begin
            if (ram_w) ram_mem[ram_addr] <= ram_data_in;
            ram_data_out <= ram_r ? ram_mem[ram_addr] : '0;
        end
    end

    // Reference model state.
    int            m_last;
    bit            m_pend;
    int            m_owner;
    logic [DW-1:0] m_rdata;
    bit            m_rknown;
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_known [DEPTH];
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic int model_grant();
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(int g);
        if (g < 0) return '0;
        return NREQ'(1) << g;
    endfunction

    task automatic model_reset();
        m_last  = NREQ - 1;
        m_pend  = 1'b0;
        m_owner = 0;
        if (CLR) begin
            for (int a = 0; a < DEPTH; a++) begin
                ref_mem[a]   = '0;
                ref_known[a] = 1'b1;
            end
        end
    endtask

    // Clock edge: apply the model's view of the operation granted this cycle.
    task automatic advance();
        int g;
        int a;
        g = model_grant();
        @(posedge clk);
        if (g >= 0) begin
            a = int'(req_addr[g*AW +: AW]);
            if (req_we[g]) begin
                ref_mem[a]   = req_wdata[g*DW +: DW];
                ref_known[a] = 1'b1;
                m_pend       = 1'b0;
            end else begin
                m_pend   = 1'b1;
                m_owner  = g;
                m_rdata  = ref_mem[a];
                m_rknown = ref_known[a];
            end
            m_last = g;
        end else begin
            m_pend = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        int cnt;
        cnt = 0;
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        while (init_busy === 1'b1 && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        n_cmp++;
        if (init_busy !== 1'b0) begin
            n_err++;
            $display("FAIL init_wait: init_busy=%b after %0d cycles, required 0", init_busy, cnt);
        end
    endtask

    task automatic write_op(int idx, int addr, logic [DW-1:0] data);
        req_valid = onehot(idx);
        req_we[idx] = 1'b1;
        req_addr[idx*AW +: AW] = AW'(addr);
        req_wdata[idx*DW +: DW] = data;
        @(negedge clk);
        advance();
        req_valid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        req_we = '0;
        #2;
        n_cmp++;
        if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b, required 00", req_ready); end
        n_cmp++;
        if (ram_w !== 1'b0 || ram_r !== 1'b0) begin n_err++; $display("FAIL reset_wr: w=%b r=%b, required 0 0", ram_w, ram_r); end
        n_cmp++;
        if (rsp_valid !== '0) begin n_err++; $display("FAIL reset_rsp: got %b, required 00", rsp_valid); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        req_valid = '0;
        #1;
        n_cmp++;
        if (init_busy !== CLR) begin n_err++; $display("FAIL init_busy_after_reset: got %b, required %b", init_busy, CLR); end
        do_reset();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d;
        d = 64'hDEAD_BEEF_0123_4567;
        do_reset();
        req_valid = 2'b01;
        req_we[0] = 1'b1;
        req_addr[0 +: AW] = 6'd5;
        req_wdata[0 +: DW] = d;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01 || ram_w !== 1'b1 || ram_r !== 1'b0) begin
            n_err++; $display("FAIL wr_grant: ready=%b w=%b r=%b, required 01 1 0", req_ready, ram_w, ram_r);
        end
        n_cmp++;
        if (ram_addr !== 6'd5 || ram_data_in !== d) begin
            n_err++; $display("FAIL wr_payload: addr=%0d data=%h, required 5 %h", ram_addr, ram_data_in, d);
        end
        advance();
        req_we[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01 || ram_r !== 1'b1 || ram_w !== 1'b0 || ram_addr !== 6'd5) begin
            n_err++; $display("FAIL rd_grant: ready=%b r=%b w=%b addr=%0d, required 01 1 0 5", req_ready, ram_r, ram_w, ram_addr);
        end
        advance();
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL rd_rsp_valid: got %b, required 01", rsp_valid); end
        n_cmp++;
        if (rsp_rdata !== d) begin n_err++; $display("FAIL rd_rsp_data: got %h, required %h", rsp_rdata, d); end
        advance();
    endtask

    task automatic test_fairness();
        write_op(0, 1, 64'h1111_0000_AAAA_0001);
        write_op(1, 2, 64'h2222_0000_BBBB_0002);
        do_reset();
        req_valid = 2'b11;
        req_we = 2'b00;
        req_addr[0 +: AW] = 6'd1;
        req_addr[AW +: AW] = 6'd2;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) req_valid = '0;
            @(negedge clk);
            if (c < 6) begin
                n_cmp++;
                if (req_ready !== onehot(c % 2)) begin
                    n_err++; $display("FAIL fair_grant c%0d: got %b, required %b", c, req_ready, onehot(c % 2));
                end
            end
            if (c > 0) begin
                n_cmp++;
                if (rsp_valid !== onehot((c - 1) % 2)) begin
                    n_err++; $display("FAIL fair_rsp c%0d: got %b, required %b", c, rsp_valid, onehot((c - 1) % 2));
                end
                if (m_pend && m_rknown) begin
                    n_cmp++;
                    if (rsp_rdata !== m_rdata) begin
                        n_err++; $display("FAIL fair_data c%0d: got %h, required %h", c, rsp_rdata, m_rdata);
                    end
                end
            end
            advance();
        end
    endtask

    task automatic test_mixed();
        do_reset();
        req_valid = 2'b11;
        req_we = 2'b01;
        req_addr[0 +: AW] = 6'd63;
        req_wdata[0 +: DW] = 64'h1;
        req_addr[AW +: AW] = 6'd63;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ram_w === 1'b1 && ram_r === 1'b1) begin n_err++; $display("FAIL mixed_wr_excl c%0d: w=1 r=1, required not both", c); end
            n_cmp++;
            if (req_ready !== onehot(c < 2 ? c : -1)) begin
                n_err++; $display("FAIL mixed_grant c%0d: got %b, required %b", c, req_ready, onehot(c < 2 ? c : -1));
            end
            if (c == 2) begin
                n_cmp++;
                if (rsp_valid !== 2'b10 || rsp_rdata !== 64'h1) begin
                    n_err++; $display("FAIL mixed_rsp: valid=%b data=%h, required 10 1", rsp_valid, rsp_rdata);
                end
            end
            advance();
            if (c == 0) req_valid = 2'b10;
            if (c == 1) req_valid = 2'b00;
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        req_valid = 2'b01;
        req_we = 2'b00;
        req_addr[0 +: AW] = 6'd5;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL midrd_grant: got %b, required 01", req_ready); end
        advance();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rsp_valid !== '0 || req_ready !== '0 || ram_r !== 1'b0) begin
            n_err++; $display("FAIL midrd_in_reset: rsp=%b ready=%b r=%b, required 00 00 0", rsp_valid, req_ready, ram_r);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== '0) begin n_err++; $display("FAIL midrd_no_rsp c%0d: got %b, required 00", c, rsp_valid); end
        end
        do_reset();
        req_valid = 2'b11;
        req_we = 2'b00;
        req_addr[AW +: AW] = 6'd5;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL midrd_priority: got %b, required 01", req_ready); end
        advance();
        req_valid = '0;
    endtask

    task automatic test_idle();
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ram_w !== 1'b0 || ram_r !== 1'b0) begin n_err++; $display("FAIL idle_wr c%0d: w=%b r=%b, required 0 0", c, ram_w, ram_r); end
            n_cmp++;
            if (rsp_valid !== (m_pend ? onehot(m_owner) : '0)) begin
                n_err++; $display("FAIL idle_rsp c%0d: got %b, required %b", c, rsp_valid, m_pend ? onehot(m_owner) : '0);
            end
            advance();
        end
        req_valid = 2'b11;
        req_we = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== onehot(model_grant())) begin
            n_err++; $display("FAIL idle_rr_hold: got %b, required %b", req_ready, onehot(model_grant()));
        end
        advance();
        req_valid = '0;
    endtask

    task automatic test_random();
        int g;
        logic [NREQ-1:0] got;
        logic ew, er;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [NREQ-1:0] ersp;
        bit dropped;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            g = model_grant();
            ew = (g >= 0) ? req_we[g] : 1'b0;
            er = (g >= 0) ? ~req_we[g] : 1'b0;
            ea = (g >= 0) ? req_addr[g*AW +: AW] : '0;
            ed = (g >= 0) ? req_wdata[g*DW +: DW] : '0;
            ersp = m_pend ? onehot(m_owner) : '0;
            got = req_ready;
            n_cmp++;
            if (req_ready !== onehot(g)) begin n_err++; $display("FAIL rnd_grant c%0d: got %b, required %b", c, req_ready, onehot(g)); end
            n_cmp++;
            if (ram_w !== ew || ram_r !== er) begin n_err++; $display("FAIL rnd_wr c%0d: w=%b r=%b, required %b %b", c, ram_w, ram_r, ew, er); end
            n_cmp++;
            if (ram_addr !== ea || ram_data_in !== ed) begin
                n_err++; $display("FAIL rnd_bus c%0d: addr=%0d data=%h, required %0d %h", c, ram_addr, ram_data_in, ea, ed);
            end
            n_cmp++;
            if (rsp_valid !== ersp) begin n_err++; $display("FAIL rnd_rsp c%0d: got %b, required %b", c, rsp_valid, ersp); end
            if (m_pend && m_rknown) begin
                n_cmp++;
                if (rsp_rdata !== m_rdata) begin n_err++; $display("FAIL rnd_data c%0d: got %h, required %h", c, rsp_rdata, m_rdata); end
            end
            advance();
            for (int i = 0; i < NREQ; i++) begin
                dropped = 1'b0;
                if (got[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i] && $urandom_range(0, 9) == 0) begin
                    req_valid[i] = 1'b0;
                    dropped = 1'b1;
                end
                if (!req_valid[i] && !dropped && $urandom_range(0, 2) != 0) begin
                    req_valid[i] = 1'b1;
                    req_we[i] = 1'($urandom_range(0, 1));
                    req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
                    req_wdata[i*DW +: DW] = {$urandom, $urandom};
                end
            end
        end
        req_valid = '0;
        @(negedge clk);
        advance();
    endtask

`ifdef RAM_ARB_CLEAR_EN
    task automatic test_clear();
        int cnt;
        write_op(0, 10, 64'hFF);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        req_valid = 2'b01;
        req_we = 2'b00;
        req_addr[0 +: AW] = 6'd10;
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clk);
            if (init_busy !== 1'b1) break;
            n_cmp++;
            if (req_ready !== '0 || ram_w !== 1'b1 || ram_addr !== AW'(cnt) || ram_data_in !== '0) begin
                n_err++; $display("FAIL clr_sweep c%0d: ready=%b w=%b addr=%0d, required 00 1 %0d", cnt, req_ready, ram_w, ram_addr, cnt);
            end
            cnt++;
        end
        n_cmp++;
        if (cnt != 64) begin n_err++; $display("FAIL clr_busy_len: got %0d cycles, required 64", cnt); end
        n_cmp++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL clr_first_run: got %b, required 01", req_ready); end
        advance();
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== '0) begin
            n_err++; $display("FAIL clr_read: valid=%b data=%h, required 01 0", rsp_valid, rsp_rdata);
        end
        advance();
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        m_rdata = '0;
        m_rknown = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            ref_mem[a] = '0;
            ref_known[a] = 1'b0;
        end
        model_reset();
        test_reset();
        test_write_read();
        test_fairness();
        test_mixed();
        test_reset_mid_read();
        test_idle();
        test_random();
`ifdef RAM_ARB_CLEAR_EN
        test_clear();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
